// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the PC sequencer.
//   pc_state_e   - sequencer FSM states (S_IDLE, S_REQ, S_HOLD)
//   redir_kind_e - kind of redirect held in the pending buffer (NONE, BRANCH, FLUSH)
package pc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        FLUSH  = 2'd2
    } redir_kind_e;

    // True when a redirect is waiting to be applied on the next ack.
    function automatic logic has_redirect(input redir_kind_e kind);
        return kind != NONE;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one pending redirect (branch or flush) that arrived
// while a fetch request was outstanding and not yet acked.
//   i_clk, i_rst_n           clock, async active-low reset (clears the buffer)
//   i_capture                a redirect may be recorded this cycle (request outstanding, no ack)
//   i_consume                the ack that applies the pending redirect; empties the buffer
//   i_br_valid/i_br_target   branch strobe and target
//   i_flush/i_flush_pc       flush strobe and handler address
//   o_kind/o_target          pending redirect kind and target
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int NPC = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_capture,
    input  logic            i_consume,
    input  logic            i_br_valid,
    input  logic [NPC-1:0]  i_br_target,
    input  logic            i_flush,
    input  logic [NPC-1:0]  i_flush_pc,
    output redir_kind_e     o_kind,
    output logic [NPC-1:0]  o_target
);

    redir_kind_e    kind_q, kind_d;
    logic [NPC-1:0] tgt_q, tgt_d;

    // A flush always replaces whatever is pending; a branch only fills an
    // empty slot or replaces an older branch, never a pending flush.
    always_comb begin
        kind_d = kind_q;
        tgt_d  = tgt_q;
        if (i_consume) begin
            kind_d = NONE;
        end else if (i_capture) begin
            if (i_flush) begin
                kind_d = FLUSH;
                tgt_d  = i_flush_pc;
            end else if (i_br_valid && (kind_q != FLUSH)) begin
                kind_d = BRANCH;
                tgt_d  = i_br_target;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kind_q <= NONE;
            tgt_q  <= '0;
        end else begin
            kind_q <= kind_d;
            tgt_q  <= tgt_d;
        end
    end

    assign o_kind   = kind_q;
    assign o_target = tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch PC sequencer with branch/flush redirect.
//   i_clk, i_rst_n             clock, async active-low reset
//   i_stall_req                hold the PC and issue no new fetch after the current one
//   i_br_valid/i_br_target     branch redirect strobe and target
//   i_flush/i_flush_pc         exception flush strobe and handler address
//   i_if_ack                   instruction memory accepts the current request
//   o_pc                       fetch address
//   o_ce                       fetch enable (low only in S_IDLE)
//   o_if_req                   fetch request (high in S_REQ)
//   o_if_valid                 registered one-cycle pulse, the cycle after an ack
//                              whose fetch was not killed by a redirect
// All outputs come from flops, so o_if_valid trails its ack by one cycle.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          NPC    = 6,
    parameter int unsigned RST_PC = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall_req,
    input  logic            i_br_valid,
    input  logic [NPC-1:0]  i_br_target,
    input  logic            i_flush,
    input  logic [NPC-1:0]  i_flush_pc,
    input  logic            i_if_ack,
    output logic [NPC-1:0]  o_pc,
    output logic            o_ce,
    output logic            o_if_req,
    output logic            o_if_valid
);

    localparam logic [NPC-1:0] RST_PC_V = RST_PC[NPC-1:0];

    pc_state_e      state_q, state_d;
    logic [NPC-1:0] pc_q, pc_d;
    logic           ifv_q, ifv_d;

    redir_kind_e    pend_kind;
    logic [NPC-1:0] pend_tgt;
    logic           in_req;
    logic           acked;

    assign in_req = (state_q == S_REQ);
    assign acked  = in_req && i_if_ack;

    // Redirects are only buffered while a request waits for its ack; a
    // redirect arriving with the ack is applied directly instead.
    pc_redirect_buf #(
        .NPC (NPC)
    ) u_redirect_buf (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_capture   (in_req && !i_if_ack),
        .i_consume   (acked),
        .i_br_valid  (i_br_valid),
        .i_br_target (i_br_target),
        .i_flush     (i_flush),
        .i_flush_pc  (i_flush_pc),
        .o_kind      (pend_kind),
        .o_target    (pend_tgt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifv_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // pc_q still holds RST_PC, so the first fetch is RST_PC.
                state_d = S_REQ;
            end
            S_REQ: begin
                // Without an ack the address is held stable and stall is
                // ignored: an outstanding request is never withdrawn.
                if (i_if_ack) begin
                    ifv_d = !(has_redirect(pend_kind) || i_flush || i_br_valid);
                    if (has_redirect(pend_kind)) pc_d = pend_tgt;
                    else if (i_flush)            pc_d = i_flush_pc;
                    else if (i_br_valid)         pc_d = i_br_target;
                    else                         pc_d = pc_q + 1'b1;
                    if (i_stall_req) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // No request outstanding, so redirects load the PC at once.
                if (i_flush)         pc_d = i_flush_pc;
                else if (i_br_valid) pc_d = i_br_target;
                if (!i_stall_req) state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = RST_PC_V;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC_V;
            ifv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifv_q   <= ifv_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_ce       = (state_q != S_IDLE);
    assign o_if_req   = in_req;
    assign o_if_valid = ifv_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter NPC, default 6, PC width in bits.
REQ-002 Parameter RST_PC, default 0, first fetch address after reset.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_stall_req  input  1  pipeline stall request; hold PC, issue no new fetch.
REQ-006 i_br_valid  input  1  branch redirect strobe, single cycle.
REQ-007 i_br_target  input  NPC  branch target, sampled when i_br_valid=1.
REQ-008 i_flush  input  1  exception flush strobe, single cycle.
REQ-009 i_flush_pc  input  NPC  handler address, sampled when i_flush=1.
REQ-010 i_if_ack  input  1  instruction memory accepts current request.
REQ-011 o_pc  output  NPC  fetch address.
REQ-012 o_ce  output  1  fetch enable; 0 only in S_IDLE.
REQ-013 o_if_req  output  1  fetch request to instruction memory.
REQ-014 o_if_valid  output  1  one-cycle pulse: the acked fetch is architecturally valid.

Function
REQ-015 The block SHALL implement states S_IDLE, S_REQ and S_HOLD.
REQ-016 S_IDLE: o_ce=0, o_if_req=0, o_pc=RST_PC; the block SHALL move to S_REQ unconditionally on the first clock after reset release.
REQ-017 S_REQ: o_if_req=1; o_pc SHALL remain stable until the cycle i_if_ack=1 (request-hold rule).
REQ-018 On ack in S_REQ: next PC selected by priority: pending flush > pending branch > same-cycle i_flush > same-cycle i_br_valid > o_pc+1.
REQ-019 o_pc+1 SHALL wrap modulo 2^NPC (all-ones -> 0).
REQ-020 After ack: i_stall_req=1 -> S_HOLD, else remain in S_REQ with new PC (back-to-back fetch, one per cycle).
REQ-021 S_HOLD: o_if_req=0; i_flush or i_br_valid SHALL load o_pc immediately (next edge), flush winning; exit to S_REQ when i_stall_req=0.
REQ-022 Redirect in S_REQ without ack: target SHALL be captured in a pending register; flush overwrites a pending branch; a branch never overwrites a pending flush.
REQ-023 Redirect in the same cycle as ack: applied directly as next PC; nothing pended.
REQ-024 o_if_valid SHALL equal i_if_ack in S_REQ except when the acked fetch is killed: killed if a redirect is pending or arrives the same cycle.
REQ-025 Pending register SHALL clear on the ack that consumes it.
REQ-026 i_stall_req SHALL NOT drop o_if_req while a request is outstanding.
REQ-027 i_if_ack outside S_REQ SHALL be ignored.

Reset
REQ-028 Asserting i_rst_n=0 at any time SHALL asynchronously force S_IDLE, o_pc=RST_PC, o_ce=0, o_if_req=0, o_if_valid=0 and clear pending redirect, including mid-request.
REQ-029 First fetch after release SHALL present RST_PC with o_ce=1 (not RST_PC+1).

Structure
REQ-030 Package pc_pkg SHALL hold the state enum (S_IDLE, S_REQ, S_HOLD) and the redirect-kind enum (NONE, BRANCH, FLUSH).
REQ-031 Sub-module pc_redirect_buf SHALL hold the pending kind/target with the REQ-022 overwrite priority; the FSM and PC register stay in pc_sequencer.
REQ-032 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Verification
REQ-033 Reset release, i_if_ack tied 1 -> o_pc 0,1,2,... one per cycle, o_if_valid=1 from first ack; with NPC=6, 63 -> 0.
REQ-034 i_if_ack=0 for 3 cycles at pc=5 with i_br_valid/target=20 in the 2nd -> o_pc stays 5; ack: o_if_valid=0, next o_pc=20.
REQ-035 Same as 034 plus i_flush/pc=40 the next cycle -> after ack o_pc=40, o_if_valid=0.
REQ-036 i_stall_req=1 while ack at pc=7 -> o_if_req=0, o_pc=8 held; drop stall -> request 8 next cycle.
REQ-037 In S_HOLD pulse i_br_valid and i_flush together (targets 9, 30) -> o_pc=30; release stall -> fetch 30.
REQ-038 Assert i_rst_n=0 mid-request at pc=12 with pending branch -> immediately o_pc=0, o_ce=0, o_if_req=0; after release first fetch is 0, branch discarded.
